// File: rtl/data_mem.sv
// -----------------------------------------------------------------------------
// data_mem
//
// Simple dual-port synchronous data memory for the frame-buffer datapath.
// One write port and one registered read port share a single clock. Depth is
// 2^ADDR_WIDTH words of DATA_WIDTH bits.
//
// Ports:
//   clk      in   1           sole clock, all state updates on rising edge
//   reset    in   1           synchronous reset, active-low
//   wr_en    in   1           write enable, active-low (0 = write)
//   rd_en    in   1           read enable, active-low (0 = read)
//   wr_addr  in   ADDR_WIDTH  write address
//   rd_addr  in   ADDR_WIDTH  read address
//   wr_data  in   DATA_WIDTH  write data
//   rd_data  out  DATA_WIDTH  registered read data (1-cycle latency)
//
// Behaviour summary:
//   - Reset clears rd_data only. Stored words survive reset and are undefined
//     after power-up.
//   - A write or read sampled in a reset cycle is discarded.
//   - Same-address read and write in one cycle is read-first: the read returns
//     the old word, and the new word is visible from the next read onward.
// -----------------------------------------------------------------------------
module data_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Storage array. It has no reset so that it maps onto block RAM.
    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_reg;

    // Enables are decoded once, with reset folded in, so that a reset cycle
    // suppresses both ports.
    logic wr_fire;
    logic rd_fire;

    assign wr_fire = reset & ~wr_en;
    assign rd_fire = reset & ~rd_en;

    // Write port. The array has no reset, so a reset cycle only gates the
    // write and the stored contents are left as they are.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    // Read port. The array is sampled with a non-blocking read in the same
    // edge as the write. This gives read-first behaviour on address collision
    // without any bypass logic.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data_reg <= '0;
        end else if (rd_fire) begin
            rd_data_reg <= mem_reg[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: tb/tb_data_mem.sv
// -----------------------------------------------------------------------------
// tb_data_mem
//
// Directed bench for data_mem with the default parameters (8-bit words,
// 8 entries). Inputs change 1 ns after each rising edge. rd_data is checked
// at that same point, which is well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_data_mem;

    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk;
    logic          reset;
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;

    int n_cmp;
    int n_fail;

    data_mem #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .wr_addr(wr_addr),
        .rd_addr(rd_addr),
        .wr_data(wr_data),
        .rd_data(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] exp);
        n_cmp++;
        assert (rd_data === exp) else begin
            n_fail++;
            $error("FAIL %s: rd_data=0x%02h expected=0x%02h", tag, rd_data, exp);
        end
        $display("check %-16s rd_data=0x%02h expected=0x%02h", tag, rd_data, exp);
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        reset   = 1'b0;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_addr = '0;
        rd_addr = '0;
        wr_data = '0;
        #1;

        // Power-up reset.
        step();
        step();
        check("reset_init", 8'h00);

        // Seed a known value at addr 0 so that a write leaking through reset
        // can be detected.
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = 3'd0;
        wr_data = 8'h3C;
        step();

        // Reset cycle with a write to addr 0 and a read of addr 0 requested.
        // Both must be discarded.
        reset   = 1'b0;
        wr_data = 8'hFF;
        rd_en   = 1'b0;
        rd_addr = 3'd0;
        step();
        check("reset_rd_zero", 8'h00);
        reset = 1'b1;
        wr_en = 1'b1;
        step();
        check("reset_no_write", 8'h3C);

        // Sequential writes 0x01..0x04 to addrs 0..3. The read port is idle,
        // so rd_data must hold at 0x3C.
        rd_en = 1'b1;
        wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_addr = AW'(i);
            wr_data = DW'(i + 1);
            step();
        end
        wr_en = 1'b1;
        check("idle_hold", 8'h3C);

        // Read back addrs 0 and 1.
        rd_en   = 1'b0;
        rd_addr = 3'd0;
        step();
        check("seq_rd_a0", 8'h01);
        rd_addr = 3'd1;
        step();
        check("seq_rd_a1", 8'h02);

        // Read hold: disable the read port and move the address.
        rd_en   = 1'b1;
        rd_addr = 3'd3;
        step();
        check("rd_hold", 8'h02);

        // Read back addrs 2 and 3.
        rd_en   = 1'b0;
        rd_addr = 3'd2;
        step();
        check("seq_rd_a2", 8'h03);
        rd_addr = 3'd3;
        step();
        check("seq_rd_a3", 8'h04);

        // Read-first collision at addr 5.
        rd_en   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = 3'd5;
        wr_data = 8'hAA;
        step();
        wr_data = 8'h55;
        rd_en   = 1'b0;
        rd_addr = 3'd5;
        step();
        check("collide_old", 8'hAA);
        wr_en = 1'b1;
        step();
        check("collide_new", 8'h55);

        // Write disabled for several edges. Addr 2 must keep 0x03.
        rd_en   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 3'd2;
        wr_data = 8'h77;
        step();
        step();
        step();
        rd_en   = 1'b0;
        rd_addr = 3'd2;
        step();
        check("wr_disabled", 8'h03);

        // Full range: write addr+0x10 to every address.
        rd_en = 1'b1;
        wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_addr = AW'(i);
            wr_data = DW'(i + 16);
            step();
        end
        wr_en   = 1'b1;
        rd_en   = 1'b0;
        rd_addr = 3'd7;
        step();
        check("wrap_rd_a7", 8'h17);
        rd_addr = 3'd0;
        step();
        check("wrap_rd_a0", 8'h10);

        // Simultaneous write and read to different addresses.
        wr_en   = 1'b0;
        wr_addr = 3'd6;
        wr_data = 8'h99;
        rd_addr = 3'd1;
        step();
        check("dual_rd_a1", 8'h11);
        wr_en   = 1'b1;
        rd_addr = 3'd6;
        step();
        check("dual_rd_a6", 8'h99);

        // Mid-stream reset. The write to addr 3 and the read of that cycle
        // are discarded, and rd_data clears.
        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 3'd3;
        wr_data = 8'hEE;
        rd_addr = 3'd3;
        step();
        check("mid_reset", 8'h00);
        reset = 1'b1;
        wr_en = 1'b1;
        step();
        check("post_rst_a3", 8'h13);
        rd_addr = 3'd5;
        step();
        check("post_rst_a5", 8'h15);
        rd_addr = 3'd7;
        step();
        check("post_rst_a7", 8'h17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
